// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver.
// Frame: start(0), 8 data bits LSB first, odd parity bit, stop(1).
// The serial line is synchronized, framed by an FSM that samples at bit
// midpoints, and each byte goes out through a valid/ready register stage
// with per-byte parity/frame error flags and a sticky overrun flag.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       rx_sclk_i,
  input  logic       rx_srst_n_i,
  input  logic       rx_sdata_i,
  output logic [7:0] rx_pdata_o,
  output logic       rx_pdata_valid_o,
  input  logic       rx_pready_i,
  output logic       rx_parity_err_o,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o,
  output logic       rx_busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);

  // The settle counter covers the synchronizer refill after reset.
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] SETTLE_DONE = SW'(SYNC_STAGES + 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   line_s;
  logic                   line_prev_reg;
  logic [SW-1:0]          settle_reg;

  state_t                 state_reg;
  logic [TW-1:0]          tick_reg;
  logic [2:0]             bit_reg;
  logic [7:0]             shreg_reg;
  logic                   par_err_reg;
  logic                   frm_err_reg;
  logic                   deliver_reg;
  logic                   busy_reg;

  logic [7:0]             pdata_reg;
  logic                   valid_reg;
  logic                   perr_out_reg;
  logic                   ferr_out_reg;
  logic                   overrun_reg;

  assign line_s = sync_reg[SYNC_STAGES-1];

  // Synchronizer shift chain; resets to the idle line level.
  always_ff @(posedge rx_sclk_i or negedge rx_srst_n_i) begin
    if (!rx_srst_n_i) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_sdata_i};
    end
  end

  // Previous line level for edge detection, and a settle counter so the
  // reset value of the synchronizer being flushed out by a low line is not
  // mistaken for a start edge.
  always_ff @(posedge rx_sclk_i or negedge rx_srst_n_i) begin
    if (!rx_srst_n_i) begin
      line_prev_reg <= 1'b1;
      settle_reg    <= '0;
    end else begin
      line_prev_reg <= line_s;
      if (settle_reg != SETTLE_DONE) begin
        settle_reg <= settle_reg + SETTLE_ONE;
      end
    end
  end

  // Frame FSM: start detection, midpoint sampling, parity/stop checks.
  always_ff @(posedge rx_sclk_i or negedge rx_srst_n_i) begin
    if (!rx_srst_n_i) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_reg     <= '0;
      shreg_reg   <= '0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      deliver_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      deliver_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if ((settle_reg == SETTLE_DONE) && line_prev_reg && !line_s) begin
            state_reg <= START;
            tick_reg  <= '0;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (tick_reg == TICK_MID) begin
            if (line_s) begin
              // Line went back high before mid-start: glitch, not a frame.
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= DATA;
              tick_reg  <= '0;
              bit_reg   <= '0;
            end
          end else begin
            tick_reg <= tick_reg + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_reg == TICK_END) begin
            shreg_reg <= {line_s, shreg_reg[7:1]};
            tick_reg  <= '0;
            bit_reg   <= bit_reg + 3'd1;
            if (bit_reg == 3'd7) begin
              state_reg <= PARITY;
            end
          end else begin
            tick_reg <= tick_reg + TICK_ONE;
          end
        end
        PARITY: begin
          if (tick_reg == TICK_END) begin
            par_err_reg <= (line_s != ~^shreg_reg);
            tick_reg    <= '0;
            state_reg   <= STOP;
          end else begin
            tick_reg <= tick_reg + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_reg == TICK_END) begin
            frm_err_reg <= ~line_s;
            deliver_reg <= 1'b1;
            tick_reg    <= '0;
            if (line_s) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= WAIT_IDLE;
            end
          end else begin
            tick_reg <= tick_reg + TICK_ONE;
          end
        end
        WAIT_IDLE: begin
          // A break or stuck-low line must return high before a new start.
          if (line_s) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: load on delivery if the slot is free or being accepted,
  // otherwise drop the frame and flag overrun until the next accept.
  always_ff @(posedge rx_sclk_i or negedge rx_srst_n_i) begin
    if (!rx_srst_n_i) begin
      pdata_reg    <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (deliver_reg && (!valid_reg || rx_pready_i)) begin
        pdata_reg    <= shreg_reg;
        perr_out_reg <= par_err_reg;
        ferr_out_reg <= frm_err_reg;
        valid_reg    <= 1'b1;
      end else if (valid_reg && rx_pready_i) begin
        valid_reg <= 1'b0;
      end

      if (valid_reg && rx_pready_i) begin
        overrun_reg <= 1'b0;
      end else if (deliver_reg && valid_reg) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign rx_pdata_o       = pdata_reg;
  assign rx_pdata_valid_o = valid_reg;
  assign rx_parity_err_o  = perr_out_reg;
  assign rx_frame_err_o   = ferr_out_reg;
  assign rx_overrun_o     = overrun_reg;
  assign rx_busy_o        = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed stimulus for uart_rx with a
// frame-level expectation queue and a per-cycle handshake checker.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int SS = 2;
  localparam int EXP_LAT = SS + 1 + OS / 2 + 10 * OS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sdata;
  logic [7:0] pdata;
  logic       valid;
  logic       pready;
  logic       perr;
  logic       ferr;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .rx_sclk_i        (clk),
    .rx_srst_n_i      (rst_n),
    .rx_sdata_i       (sdata),
    .rx_pdata_o       (pdata),
    .rx_pdata_valid_o (valid),
    .rx_pready_i      (pready),
    .rx_parity_err_o  (perr),
    .rx_frame_err_o   (ferr),
    .rx_overrun_o     (overrun),
    .rx_busy_o        (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   pready_mode = 0;   // 0 always ready, 1 random stalls, 2 never, 3 manual

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity_bit(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic push_expect(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    e.d  = d;
    e.pe = (p != odd_parity_bit(d));
    e.fe = !s;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    sdata = v;
    tick(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic wait_valid(output int lat, output logic [7:0] d, output logic pe, output logic fe);
    int t0;
    t0  = cyc;
    lat = -1;
    d   = '0;
    pe  = 1'b0;
    fe  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = cyc - t0;
        d   = pdata;
        pe  = perr;
        fe  = ferr;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: got no valid in 400 cycles, required one");
    end
  endtask

  task automatic frame_and_wait(input string name, input logic [7:0] d, input logic p,
                                input logic s, input logic [7:0] xd, input logic xpe,
                                input logic xfe);
    int lat;
    logic [7:0] got_d;
    logic got_pe, got_fe;
    push_expect(d, p, s);
    fork
      send_frame(d, p, s);
      wait_valid(lat, got_d, got_pe, got_fe);
    join
    check({name, "_data"}, got_d, xd);
    check({name, "_perr"}, got_pe, xpe);
    check({name, "_ferr"}, got_fe, xfe);
    $display("frame %s: byte %02h perr %0d ferr %0d latency %0d", name, got_d, got_pe, got_fe, lat);
    if (name == "t1") begin
      n_checks++;
      if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2) begin
        n_fail++;
        $display("FAIL latency: got %0d, required %0d +-2", lat, EXP_LAT);
      end
    end
  endtask

  // Consumer: drives pready according to the current mode.
  initial begin
    int stall;
    stall  = 0;
    pready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (pready_mode)
        0: pready = 1'b1;
        1: begin
          pready = (stall >= 40) || ($urandom_range(0, 7) == 0);
          if (pready || !valid) stall = 0;
          else stall++;
        end
        2: pready = 1'b0;
        default: ;
      endcase
    end
  end

  // Compare process: every accepted byte against the expectation queue, and
  // held outputs stable across every stalled cycle.
  logic       prev_ok = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_pready = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_pe = 1'b0;
  logic       prev_fe = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_ok && prev_valid && !prev_pready) begin
        check("hold_valid", valid, 1'b1);
        check("hold_data", pdata, prev_data);
        check("hold_perr", perr, prev_pe);
        check("hold_ferr", ferr, prev_fe);
      end
      if (valid && pready) begin
        accepts++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %02h, required no byte", pdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("model_data", pdata, e.d);
          check("model_perr", perr, e.pe);
          check("model_ferr", ferr, e.fe);
          $display("accept: byte %02h perr %0d ferr %0d", pdata, perr, ferr);
        end
      end
    end
    prev_ok     <= rst_n;
    prev_valid  <= valid;
    prev_pready <= pready;
    prev_data   <= pdata;
    prev_pe     <= perr;
    prev_fe     <= ferr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, pdata, 8'h00);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_perr"}, perr, 1'b0);
    check({tag, "_ferr"}, ferr, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int acc0;
    logic busy_seen;
    logic [7:0] v;
    logic [7:0] rd;
    logic rp, rs;
    int gap;

    rst_n = 1'b0;
    sdata = 1'b1;
    tick(5);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(10);

    // Clean frame with correct parity; also pins latency.
    frame_and_wait("t1", 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    tick(20);
    check("t1_overrun", overrun, 1'b0);
    check("t1_busy_idle", busy, 1'b0);

    // Wrong parity bit.
    frame_and_wait("t2", 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    tick(20);

    // Stop bit low, then line held low: one byte, no re-detection.
    acc0 = accepts;
    frame_and_wait("t3", 8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
    tick(40);
    check("t3_busy_wait", busy, 1'b1);
    sdata = 1'b1;
    tick(10);
    check("t3_busy_idle", busy, 1'b0);
    tick(50);
    check("t3_one_byte", accepts - acc0, 1);

    // Short glitch: false start, nothing delivered.
    acc0 = accepts;
    busy_seen = 1'b0;
    sdata = 1'b0;
    tick(4);
    sdata = 1'b1;
    for (int i = 0; i < OS / 2 + SS + 4; i++) begin
      busy_seen |= busy;
      tick(1);
    end
    check("t4_busy_seen", busy_seen, 1'b1);
    check("t4_busy_back", busy, 1'b0);
    tick(200);
    check("t4_no_byte", accepts - acc0, 0);

    // Overrun: consumer stalled across two frames.
    pready_mode = 2;
    tick(2);
    push_expect(8'h11, 1'b1, 1'b1);
    send_frame(8'h11, 1'b1, 1'b1);
    tick(20);
    check("t5_valid1", valid, 1'b1);
    check("t5_data1", pdata, 8'h11);
    check("t5_overrun0", overrun, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    tick(20);
    check("t5_valid2", valid, 1'b1);
    check("t5_data_kept", pdata, 8'h11);
    check("t5_overrun1", overrun, 1'b1);
    pready_mode = 3;
    pready = 1'b1;
    tick(1);
    pready = 1'b0;
    tick(1);
    check("t5_valid_clr", valid, 1'b0);
    check("t5_overrun_clr", overrun, 1'b0);
    pready_mode = 0;
    tick(5);
    frame_and_wait("t5c", 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
    check("t5c_overrun", overrun, 1'b0);
    tick(20);

    // Reset during data bit 4, release with the line low.
    v = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v[i]);
    sdata = v[4];
    tick(8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    sdata = 1'b0;
    tick(5);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      busy_seen |= busy;
      tick(1);
    end
    check("t6_no_start_low", busy_seen, 1'b0);
    check("t6_no_valid", valid, 1'b0);
    sdata = 1'b1;
    tick(30);
    frame_and_wait("t6", 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    tick(20);

    // Randomized frames with random stalls short enough to avoid overrun.
    for (int n = 0; n < 12; n++) begin
      pready_mode = $urandom_range(0, 1);
      rd = 8'($urandom);
      rp = odd_parity_bit(rd) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(3, 40);
      $display("send: byte %02h parity %0d stop %0d gap %0d mode %0d", rd, rp, rs, gap, pready_mode);
      push_expect(rd, rp, rs);
      send_frame(rd, rp, rs);
      sdata = 1'b1;
      tick(gap);
    end
    pready_mode = 0;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
    check("drain_queue", exp_q.size(), 0);
    tick(10);
    check("end_overrun", overrun, 1'b0);
    check("end_valid", valid, 1'b0);
    check("end_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
